// File: rtl/rv32i_types.sv
// Shared type package for the rv32i pipeline.
//
// Contents:
//   REG_IDX_W   - architectural register index width (x0..x31)
//   PERF_CNT_W  - width of the optional hazard performance counters
//   hz_state_t  - memory-completion tracking state of pipeline_hazard_ctrl
package rv32i_types;

    localparam int REG_IDX_W  = 5;
    localparam int PERF_CNT_W = 32;

    // HZ_RUN    : no memory response latched yet for the current advance
    // HZ_I_DONE : fetch already completed, still waiting on the data access
    // HZ_D_DONE : data access already completed, still waiting on the fetch
    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_I_DONE = 2'd1,
        HZ_D_DONE = 2'd2
    } hz_state_t;

endpackage : rv32i_types

// File: rtl/hazard_detect.sv
// hazard_detect - purely combinational load-use comparator.
//
// Flags the case where the instruction in EX is a load whose destination
// register is read by the instruction in ID; the value is not forwardable
// until the load reaches MEM, so ID must wait one cycle.
//
// Ports:
//   id_rs1, id_rs2            in  REG_IDX_W - source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2  in  1         - ID instruction actually reads that source
//   ex_rd                     in  REG_IDX_W - destination register of the EX instruction
//   ex_mem_read               in  1         - EX instruction is a load
//   load_use                  out 1         - load-use hazard present
module hazard_detect
    import rv32i_types::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule : hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl - central hazard/stall controller of the five-stage
// rv32i pipeline.
//
// Every cycle it produces the load/sel pair for each inter-stage register
// plus the PC load enable. The whole pipeline freezes until both the fetch
// and (if requested) the data access of the current cycle have completed;
// a response that arrives early is remembered in the FSM so it is never
// required twice. A load-use hazard inserts a single bubble into ID/EX, and
// a taken branch/jump in EX flushes IF/ID and ID/EX.
//
// Optional feature macro: HAZARD_PERF_EN adds the stall_cycles and
// flush_count performance counters.
//
// Ports:
//   clk, rst                      in  1  - clock, synchronous active-high reset
//   id_rs1, id_rs2                in  5  - ID source registers
//   id_uses_rs1, id_uses_rs2      in  1  - ID instruction reads that source
//   ex_rd                         in  5  - EX destination register
//   ex_mem_read                   in  1  - EX instruction is a load
//   ex_br_taken                   in  1  - EX branch/jump taken
//   imem_resp                     in  1  - fetch completes this cycle
//   dmem_req                      in  1  - MEM instruction accesses memory
//   dmem_resp                     in  1  - data access completes this cycle
//   pc_load                       out 1  - load PC
//   {if_id,id_ex,ex_mem,mem_wb}_load  out 1 - stage register load enables
//   {if_id,id_ex,ex_mem,mem_wb}_sel   out 1 - 1 = load bubble, 0 = pass-through
//   stall_cycles, flush_count     out 32 - (HAZARD_PERF_EN only) counters
module pipeline_hazard_ctrl
    import rv32i_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_br_taken,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_sel,
    output logic                 id_ex_sel,
    output logic                 ex_mem_sel,
    output logic                 mem_wb_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);

    hz_state_t state;
    logic      load_use;
    logic      i_done;
    logic      d_done;
    logic      i_ok;
    logic      d_ok;
    logic      advance;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign i_done  = (state == HZ_I_DONE);
    assign d_done  = (state == HZ_D_DONE);
    assign i_ok    = imem_resp || i_done;
    assign d_ok    = !dmem_req || dmem_resp || d_done;
    assign advance = i_ok && d_ok;

    // Completion tracking: remember whichever response arrived first while
    // the other is still outstanding, and drop it once the pair is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (advance)
                        state <= HZ_RUN;
                    else if (imem_resp && !d_ok)
                        state <= HZ_I_DONE;
                    else if (dmem_req && dmem_resp && !imem_resp)
                        state <= HZ_D_DONE;
                    else
                        state <= HZ_RUN;
                end
                HZ_I_DONE: begin
                    if (dmem_resp)
                        state <= HZ_RUN;
                end
                HZ_D_DONE: begin
                    if (imem_resp)
                        state <= HZ_RUN;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    // Stage control decode. A branch outranks load-use because the ID
    // instruction that would have consumed the load is flushed anyway.
    always_comb begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        if_id_sel   = 1'b0;
        id_ex_sel   = 1'b0;
        ex_mem_sel  = 1'b0;
        mem_wb_sel  = 1'b0;
        if (rst || !advance) begin
            // full freeze: defaults already hold
        end else if (ex_br_taken) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if_id_sel   = 1'b1;
            id_ex_sel   = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, let the load move on, drop a bubble into EX.
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            id_ex_sel   = 1'b1;
        end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic bubble;

    assign bubble = advance && !ex_br_taken && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!advance || bubble)
                stall_cycles <= stall_cycles + 1'b1;
            if (advance && ex_br_taken)
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a vector table of
// single-cycle cases, hand-written multi-cycle sequences, then random
// stimulus checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ir;
        logic       dq;
        logic       ds;
        logic [8:0] exp;
    } vec_t;

    // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id, id_ex, ex_mem, mem_wb sels}
    localparam logic [8:0] O_FRZ = 9'b0_0000_0000;
    localparam logic [8:0] O_RUN = 9'b1_1111_0000;
    localparam logic [8:0] O_LU  = 9'b0_0111_0100;
    localparam logic [8:0] O_BR  = 9'b1_1111_1100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic       imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic       if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          i_got = 0;
    bit          d_got = 0;
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_br_taken (ex_br_taken),
        .imem_resp   (imem_resp),
        .dmem_req    (dmem_req),
        .dmem_resp   (dmem_resp),
        .pc_load     (pc_load),
        .if_id_load  (if_id_load),
        .id_ex_load  (id_ex_load),
        .ex_mem_load (ex_mem_load),
        .mem_wb_load (mem_wb_load),
        .if_id_sel   (if_id_sel),
        .id_ex_sel   (id_ex_sel),
        .ex_mem_sel  (ex_mem_sel),
        .mem_wb_sel  (mem_wb_sel)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    function automatic bit m_lu();
        if (!ex_mem_read || ex_rd == 5'd0) return 0;
        return (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    endfunction

    function automatic bit m_dok();
        return !dmem_req || dmem_resp || d_got;
    endfunction

    function automatic bit m_adv();
        return (imem_resp || i_got) && m_dok();
    endfunction

    function automatic logic [8:0] m_out();
        if (rst || !m_adv()) return O_FRZ;
        if (ex_br_taken)     return O_BR;
        if (m_lu())          return O_LU;
        return O_RUN;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_br_taken = v.br;
        imem_resp = v.ir; dmem_req = v.dq; dmem_resp = v.ds;
    endtask

    // Compares against an explicit expectation; counters against the model.
    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] got;
        #3;
        got = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
`ifdef HAZARD_PERF_EN
        total++;
        if (stall_cycles !== stall_m || flush_count !== flush_m) begin
            bad++;
            $display("FAIL %s perf: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                     name, stall_cycles, flush_count, stall_m, flush_m);
        end
`endif
    endtask

    // Advance one clock and update the model with the inputs of that cycle.
    task automatic tick();
        bit adv;
        @(posedge clk);
        adv = m_adv();
        if (rst) begin
            i_got = 0; d_got = 0; stall_m = '0; flush_m = '0;
        end else begin
            if (!adv || (!ex_br_taken && m_lu())) stall_m = stall_m + 1;
            if (adv && ex_br_taken) flush_m = flush_m + 1;
            if (!i_got && !d_got) begin
                if (!adv) begin
                    if (imem_resp && !m_dok())                        i_got = 1;
                    else if (dmem_req && dmem_resp && !imem_resp)     d_got = 1;
                end
            end else if (i_got) begin
                if (dmem_resp) i_got = 0;
            end else if (imem_resp) begin
                d_got = 0;
            end
        end
        #1;
    endtask

    task automatic step(input string name, input vec_t v, input logic [8:0] exp);
        drive(v);
        check(name, exp);
        tick();
    endtask

    function automatic vec_t mk(string n, int rs1, int rs2, bit u1, bit u2, int rd,
                                bit mr, bit br, bit ir, bit dq, bit ds, logic [8:0] e);
        vec_t v;
        v.name = n; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.mr = mr; v.br = br; v.ir = ir; v.dq = dq; v.ds = ds;
        v.exp = e;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Every table entry leaves the controller in HZ_RUN.
        tbl.push_back(mk("nodep",      1, 2, 1, 1, 3, 1, 0, 1, 0, 0, O_RUN));
        tbl.push_back(mk("lu_rs2",     0, 5, 0, 1, 5, 1, 0, 1, 0, 0, O_LU));
        tbl.push_back(mk("lu_rs1_x31",31, 2, 1, 0,31, 1, 0, 1, 0, 0, O_LU));
        tbl.push_back(mk("rd_x0",      0, 0, 1, 1, 0, 1, 0, 1, 0, 0, O_RUN));
        tbl.push_back(mk("rs1_unused", 7, 1, 0, 1, 7, 1, 0, 1, 0, 0, O_RUN));
        tbl.push_back(mk("not_load",   7, 1, 1, 1, 7, 0, 0, 1, 0, 0, O_RUN));
        tbl.push_back(mk("br_over_lu", 5, 0, 1, 0, 5, 1, 1, 1, 0, 0, O_BR));
        tbl.push_back(mk("no_imem",    1, 2, 1, 1, 3, 0, 0, 0, 0, 0, O_FRZ));
        tbl.push_back(mk("d_wait",     1, 2, 1, 1, 3, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk("both_resp",  1, 2, 1, 1, 3, 0, 0, 1, 1, 1, O_RUN));
        tbl.push_back(mk("br_dmem",    1, 2, 1, 1, 3, 0, 1, 1, 1, 1, O_BR));
        tbl.push_back(mk("frz_br_lu",  5, 5, 1, 1, 5, 1, 1, 0, 1, 0, O_FRZ));

        @(posedge clk); #1;

        // reset: outputs frozen even with responses present
        rst = 1'b1;
        step("rst_a", mk("", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_FRZ);
        step("rst_b", mk("", 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), O_FRZ);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            step($sformatf("run%0d", i), mk("", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RUN);

        foreach (tbl[i]) step(tbl[i].name, tbl[i], tbl[i].exp);

        // load-use bubble lasts one cycle
        step("lu_c0", mk("", 0, 5, 0, 1, 5, 1, 0, 1, 0, 0, 0), O_LU);
        step("lu_c1", mk("", 0, 5, 0, 1, 5, 0, 0, 1, 0, 0, 0), O_RUN);

        // fetch early, data access completes three cycles later
        step("iw_c0", mk("", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_FRZ);
        step("iw_c1", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_FRZ);
        step("iw_c2", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_FRZ);
        step("iw_c3", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_RUN);
        step("iw_c4", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_FRZ);

        // data early, fetch later
        step("dw_c0", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_FRZ);
        step("dw_c1", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_FRZ);
        step("dw_c2", mk("", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), O_BR);

        // reset while a data completion is latched discards it
        step("rd_c0", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_FRZ);
        rst = 1'b1;
        step("rd_c1", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_FRZ);
        rst = 1'b0;
        step("rd_c2", mk("", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_FRZ);
        step("rd_c3", mk("", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_RUN);

        // branch with load-use: flush wins, flush counter 0 -> 1
        rst = 1'b1;
        step("br_rst", mk("", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_FRZ);
        rst = 1'b0;
        step("br_lu", mk("", 3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 0), O_BR);
        step("br_after", mk("", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RUN);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            v = mk("", $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            rst = ($urandom_range(0, 40) == 0);
            drive(v);
            check($sformatf("rand%0d", i), m_out());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the five-stage rv32i pipeline. Each cycle it generates the `load`/`sel` pair for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC load enable. It freezes the whole pipeline while instruction or data memory responses are outstanding. It inserts a one-cycle bubble for load-use hazards and flushes the two younger stages on a taken branch or jump.

## Interface
- No parameters; widths come from `rv32i_types`.
- `clk` in 1 — clock
- `rst` in 1 — reset; synchronous, active-high
- `id_rs1`, `id_rs2` in 5 each — source registers of the instruction in ID
- `id_uses_rs1`, `id_uses_rs2` in 1 each — ID instruction actually reads that source
- `ex_rd` in 5 — destination register of the instruction in EX
- `ex_mem_read` in 1 — instruction in EX is a load
- `ex_br_taken` in 1 — branch or jump in EX resolved as taken (PC redirect)
- `imem_resp` in 1 — instruction fetch completes this cycle; a fetch is always requested
- `dmem_req` in 1 — instruction in MEM issues a read or write
- `dmem_resp` in 1 — data access completes this cycle
- `pc_load` out 1 — load PC
- `if_id_load`, `id_ex_load`, `ex_mem_load`, `mem_wb_load` out 1 — stage register load enables
- `if_id_sel`, `id_ex_sel`, `ex_mem_sel`, `mem_wb_sel` out 1 — 1 = load zero (bubble), 0 = pass-through

## Operation
- **Hazard conditions**
  - `load_use` = `ex_mem_read` & `ex_rd` != 0 & ((`id_uses_rs1` & `id_rs1` == `ex_rd`) | (`id_uses_rs2` & `id_rs2` == `ex_rd`)).
- **Completion and advance**
  - `i_ok` = `imem_resp` | `i_done`.
  - `d_ok` = !`dmem_req` | `dmem_resp` | `d_done`.
  - `advance` = `i_ok` & `d_ok`.
- **FSM** (`hz_state_t`: `HZ_RUN`, `HZ_I_DONE`, `HZ_D_DONE`)
  - `i_done`/`d_done` are decoded from the state.
  - `HZ_RUN`:
    - `advance` → stay in `HZ_RUN`.
    - `imem_resp` without `d_ok` → `HZ_I_DONE`.
    - `dmem_req` & `dmem_resp` without `imem_resp` → `HZ_D_DONE`.
    - Otherwise stay.
  - `HZ_I_DONE`: `dmem_resp` → `HZ_RUN`; otherwise stay.
  - `HZ_D_DONE`: `imem_resp` → `HZ_RUN`; otherwise stay.
- **Outputs, in priority order**
  1. `rst` or !`advance`: all loads 0, all sels 0 (full freeze).
  2. `advance` & `ex_br_taken`:
     - all loads 1;
     - `if_id_sel` = `id_ex_sel` = 1 (flush the two younger instructions);
     - other sels 0.
     - `load_use` is ignored because the ID instruction is being flushed.
  3. `advance` & `load_use`:
     - `pc_load` = `if_id_load` = 0;
     - `id_ex_load` = 1 with `id_ex_sel` = 1 (bubble);
     - `ex_mem_load` = `mem_wb_load` = 1;
     - other sels 0.
  4. `advance`: all loads 1, all sels 0.
- A stalled branch or load remains in EX, so its redirect or bubble is applied on the advancing cycle.

## Timing
- All outputs are combinational from inputs and state: zero-cycle latency. The registers they drive update on the next `clk` edge.
- State updates on posedge `clk`. `rst` forces `HZ_RUN` and clears the performance counters.
- Simultaneous `imem_resp` and `dmem_resp` in `HZ_RUN` → advance in that cycle; no state change.
- A response already latched (`i_done` or `d_done`) is never required again.
- `rst` asserted mid-wait → `HZ_RUN` next cycle; any latched completion is discarded.
- A load-use bubble always costs exactly one cycle: the next cycle the load is in MEM and `load_use` deasserts.

## Configuration
- `HAZARD_PERF_EN`
  - Defined: adds outputs `stall_cycles` (32) and `flush_count` (32), both reset to 0.
    - `stall_cycles` increments every cycle with !`advance` or a load-use bubble.
    - `flush_count` increments on each `advance` & `ex_br_taken`.
    - Both wrap at 2^32.
  - Undefined: ports and logic absent; all other behaviour is identical.

## Structure
- `hz_state_t` enum belongs in the shared package `rv32i_types`.
- One sub-module, `hazard_detect`: purely combinational `load_use` comparator.
- FSM, output decode and optional counters live in the top module.

## Test plan
- Reset, then `imem_resp`=1, `dmem_req`=0 for 3 cycles → all loads 1, all sels 0 each cycle.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1, `imem_resp`=1 → `pc_load`=0, `if_id_load`=0, `id_ex_sel`=1; next cycle with `ex_mem_read`=0 → normal advance.
- `ex_rd`=0 with a matching `id_rs1`=0 and a load in EX → no bubble.
- `dmem_req`=1; `imem_resp` at cycle 0; `dmem_resp` at cycle 3:
  - state `HZ_I_DONE` during cycles 1–3;
  - loads 0 in cycles 0–2;
  - loads 1 in cycle 3;
  - back to `HZ_RUN`.
- `ex_br_taken`=1 together with `load_use`=1 and `advance` → all loads 1, `if_id_sel`=`id_ex_sel`=1; with `HAZARD_PERF_EN`, `flush_count` goes 0 → 1.
- `rst` pulsed while in `HZ_D_DONE` → next cycle `HZ_RUN`; a subsequent `imem_resp` alone with `dmem_req`=1 does not advance.
